// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer: slot state encodings
// and the default parameter values used by the top level.
package stream_demux_pkg;

    // Slot occupancy: a slot either holds one beat or it does not.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam int DEF_SIZE    = 16;
    localparam int DEF_NUM_OUT = 2;
    localparam int DEF_SEL_W   = 1;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/stream_demux_slot.sv
// One-entry register slice used for each output port of stream_demux.
//
//   state      | meaning
//   -----------+---------------------------------------------
//   SLOT_EMPTY | no beat held, valid low
//   SLOT_FULL  | beat held on data, valid high until drained
//
// The parent only asserts load when the slot is empty or being drained in
// the same cycle, so a load always wins over a drain (no bubble).
module demux_slot
    import stream_demux_pkg::*;
#(
    parameter int SIZE = DEF_SIZE
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [SIZE-1:0] load_data,
    input  logic            drain,
    output logic            valid,
    output logic [SIZE-1:0] data
);

    slot_state_t state;

    // Slot occupancy and held data; data only changes on a load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SLOT_EMPTY;
            data  <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: begin
                    if (load) begin
                        state <= SLOT_FULL;
                        data  <= load_data;
                    end
                end
                SLOT_FULL: begin
                    if (load) begin
                        data <= load_data;
                    end else if (drain) begin
                        state <= SLOT_EMPTY;
                    end
                end
                default: state <= SLOT_EMPTY;
            endcase
        end
    end

    assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_OUT stream demultiplexer with per-port valid/ready.
// Each output owns a one-entry slot, so a stalled consumer only blocks beats
// addressed to itself. Beats addressed past the last port are swallowed and
// flagged on sel_err for one cycle.
// Optional feature: define STREAM_DEMUX_CNT_EN to add per-port transfer
// counters on xfer_cnt; otherwise xfer_cnt is tied to zero.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int SIZE    = DEF_SIZE,
    parameter int NUM_OUT = DEF_NUM_OUT,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic [SIZE-1:0]          in_data,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [NUM_OUT*SIZE-1:0]  out_data,
    output logic                     sel_err,
    output logic [NUM_OUT*CNT_W-1:0] xfer_cnt
);

    logic               sel_in_range;
    logic               sel_full;
    logic               sel_drain;
    logic               accept;
    logic [NUM_OUT-1:0] load;

    // Select decode and ready mux; in_valid only gates the load, never ready.
    always_comb begin
        sel_in_range = (int'(in_sel) < NUM_OUT);
        sel_full     = 1'b0;
        sel_drain    = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (int'(in_sel) == k) begin
                sel_full  = out_valid[k];
                sel_drain = out_ready[k];
            end
        end
        in_ready = ~sel_in_range | ~sel_full | sel_drain;
        accept   = in_valid & in_ready;
        load     = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            load[k] = accept & (int'(in_sel) == k);
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
        demux_slot #(
            .SIZE(SIZE)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (load[k]),
            .load_data(in_data),
            .drain    (out_ready[k]),
            .valid    (out_valid[k]),
            .data     (out_data[k*SIZE +: SIZE])
        );
    end

    // One-cycle flag for a beat that was accepted but had no destination.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= in_valid & ~sel_in_range;
        end
    end

`ifdef STREAM_DEMUX_CNT_EN
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;

        // Count completed handshakes on port k; wraps naturally.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (out_valid[k] & out_ready[k]) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign xfer_cnt[k*CNT_W +: CNT_W] = cnt_q;
    end
`else
    assign xfer_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux with three ports (2-bit select) so the
// out-of-range path is reachable.
module tb_stream_demux;

    localparam int SIZE    = 16;
    localparam int NUM_OUT = 3;
    localparam int SEL_W   = 2;
    localparam int CNT_W   = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic [SEL_W-1:0]         in_sel;
    logic [SIZE-1:0]          in_data;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic [NUM_OUT*SIZE-1:0]  out_data;
    logic                     sel_err;
    logic [NUM_OUT*CNT_W-1:0] xfer_cnt;

    int total = 0;
    int bad   = 0;

    logic [SIZE-1:0]  q[NUM_OUT][$];
    logic [CNT_W-1:0] exp_cnt[NUM_OUT];
    logic             exp_err = 1'b0;

    stream_demux #(
        .SIZE(SIZE), .NUM_OUT(NUM_OUT), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .sel_err(sel_err),
        .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one beat at posedge+1; returns at posedge+1 after it was accepted.
    task automatic send(input logic [SEL_W-1:0] sel, input logic [SIZE-1:0] d);
        bit done = 0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                if (int'(sel) < NUM_OUT) q[sel].push_back(d);
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    // Reference for sel_err: an out-of-range beat seen at an edge flags the next cycle.
    always @(posedge clk) begin
        exp_err <= !reset && in_valid && (int'(in_sel) >= NUM_OUT);
    end

    // Monitor: every completed handshake must match the oldest expected beat.
    always @(negedge clk) begin
        chk("sel_err", 64'(sel_err), 64'(exp_err));
        for (int k = 0; k < NUM_OUT; k++) begin
            if (out_valid[k] && out_ready[k]) begin
                if (q[k].size() == 0) begin
                    chk($sformatf("unexpected_beat_p%0d", k), 64'(out_data[k*SIZE +: SIZE]), 64'hDEADBEEF);
                end else begin
                    chk($sformatf("data_p%0d", k), 64'(out_data[k*SIZE +: SIZE]), 64'(q[k].pop_front()));
                end
                exp_cnt[k] = exp_cnt[k] + 1'b1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NUM_OUT; k++) exp_cnt[k] = '0;
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_sel    = '0;
        in_data   = 16'hFFFF;
        out_ready = '0;

        // Reset held with in_valid high: nothing may appear.
        repeat (3) begin
            @(negedge clk);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_data", 64'(out_data), 64'd0);
        end
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;

        // First accept after release, visible one cycle later.
        send(2'd0, 16'h1234);
        @(negedge clk);
        chk("first_valid", 64'(out_valid), 64'b001);
        chk("first_data", 64'(out_data[15:0]), 64'h1234);
        @(posedge clk); #1;
        out_ready = 3'b111;
        @(posedge clk); #1;

        // Routing to two ports back to back.
        send(2'd0, 16'hA5A5);
        @(negedge clk);
        chk("route_p0", 64'(out_data[15:0]), 64'hA5A5);
        chk("route_v0", 64'(out_valid), 64'b001);
        @(posedge clk); #1;
        send(2'd1, 16'h5A5A);
        @(negedge clk);
        chk("route_p1", 64'(out_data[31:16]), 64'h5A5A);
        chk("route_v1", 64'(out_valid), 64'b010);
        @(posedge clk); #1;

        // Backpressure on port 0 must not block port 1.
        out_ready = 3'b000;
        send(2'd0, 16'h1111);
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 16'h9999;
        @(negedge clk);
        chk("bp_in_ready_p0", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        in_sel  = 2'd1;
        in_data = 16'hBBBB;
        @(negedge clk);
        chk("bp_in_ready_p1", 64'(in_ready), 64'd1);
        q[1].push_back(16'hBBBB);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_hold_p0", 64'(out_data[15:0]), 64'h1111);
        chk("bp_data_p1", 64'(out_data[31:16]), 64'hBBBB);
        chk("bp_valid", 64'(out_valid), 64'b011);

        // Drain and accept in the same cycle on port 0: no bubble.
        @(posedge clk); #1;
        out_ready = 3'b001;
        send(2'd0, 16'h2222);
        @(negedge clk);
        chk("nobubble_valid0", 64'(out_valid[0]), 64'd1);
        chk("nobubble_data0", 64'(out_data[15:0]), 64'h2222);
        @(posedge clk); #1;
        out_ready = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("drained", 64'(out_valid), 64'd0);

        // Out-of-range select: consumed, flagged once, no slot touched.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_sel   = 2'd3;
        in_data  = 16'hDEAD;
        @(negedge clk);
        chk("oor_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("oor_sel_err", 64'(sel_err), 64'd1);
        chk("oor_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("oor_sel_err_end", 64'(sel_err), 64'd0);
        chk("oor_out_valid_end", 64'(out_valid), 64'd0);

        // Reset with a held beat discards it.
        @(posedge clk); #1;
        out_ready = 3'b000;
        send(2'd2, 16'h7777);
        @(negedge clk);
        chk("held_p2", 64'(out_valid), 64'b100);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < NUM_OUT; k++) begin
            q[k].delete();
            exp_cnt[k] = '0;
        end
        @(negedge clk);
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_data", 64'(out_data), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_valid", 64'(out_valid), 64'd0);

        // Seventeen transfers on port 1 wrap a 4-bit counter to 1.
        @(posedge clk); #1;
        out_ready = 3'b111;
        for (int i = 0; i < 17; i++) send(2'd1, 16'h0100 + 16'(i));
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
`ifdef STREAM_DEMUX_CNT_EN
        chk("xfer_cnt", 64'(xfer_cnt), 64'h010);
        chk("xfer_cnt_model", 64'(xfer_cnt), 64'({exp_cnt[2], exp_cnt[1], exp_cnt[0]}));
`else
        chk("xfer_cnt_tied", 64'(xfer_cnt), 64'h000);
`endif
        for (int k = 0; k < NUM_OUT; k++) begin
            chk($sformatf("leftover_p%0d", k), 64'(q[k].size()), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
